// File: rtl/serv_ifetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package serv_ifetch_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StDemand = 2'd1,
    StPref   = 2'd2
  } ifetch_state_e;

  // Wishbone instruction addresses are always word aligned.
  localparam logic [1:0] WB_ADR_ALIGN = 2'b00;

  // Next sequential word address; wraps modulo 2^32.
  function automatic logic [31:2] next_word(input logic [31:2] adr);
    return adr + 30'd1;
  endfunction

endpackage

// File: rtl/serv_ifetch_buf.sv
// Single-entry prefetch buffer: word address, instruction bits [31:2] and a valid bit.
module serv_ifetch_buf
  import serv_ifetch_pkg::*;
(
  input  logic        clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic [31:2] i_load_adr,
  input  logic [29:0] i_load_data,
  input  logic        i_inval,
  input  logic [31:2] i_cmp_adr,
  output logic        o_hit,
  output logic [29:0] o_data
);

  logic        valid_q;
  logic [31:2] adr_q;
  logic [29:0] data_q;

  // Invalidate wins over load so a flush can never leave stale data behind.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      adr_q   <= '0;
      data_q  <= '0;
    end else if (i_inval) begin
      valid_q <= 1'b0;
    end else if (i_load) begin
      valid_q <= 1'b1;
      adr_q   <= i_load_adr;
      data_q  <= i_load_data;
    end
  end

  assign o_hit  = valid_q && (adr_q == i_cmp_adr);
  assign o_data = data_q;

endmodule

// File: rtl/serv_ifetch.sv
// Instruction fetch front end: Wishbone ibus master with a one-entry speculative PC+4 prefetch.
module serv_ifetch
  import serv_ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter bit          PREFETCH = 1'b1
) (
  input  logic        clk,
  input  logic        i_rst,
  input  logic        i_fetch_req,
  input  logic [31:0] i_pc,
  input  logic        i_flush,
  output logic        o_busy,
  output logic [31:0] o_ibus_adr,
  output logic        o_ibus_cyc,
  input  logic [31:0] i_ibus_rdt,
  input  logic        i_ibus_ack,
  output logic [29:0] o_wb_rdt,
  output logic        o_wb_en
);

  ifetch_state_e state_q, state_d;
  logic [31:2]   adr_q, adr_d;
  logic [31:2]   pend_adr_q, pend_adr_d;
  logic          pend_valid_q, pend_valid_d;
  logic          discard_q, discard_d;
  logic          wb_en_q, wb_en_d;
  logic [29:0]   wb_rdt_q, wb_rdt_d;

  logic          busy;
  logic          req_ok;
  logic [31:2]   pc_word;
  logic          buf_hit, buf_load, buf_inval;
  logic [29:0]   buf_data;
  logic          eff_pend, eff_discard;
  logic [31:2]   eff_pend_adr;
  logic          unused_bits;

  assign pc_word     = i_pc[31:2];
  assign unused_bits = ^{i_pc[1:0], i_ibus_rdt[1:0]};

  assign busy   = (state_q == StDemand) || ((state_q == StPref) && pend_valid_q);
  assign req_ok = i_fetch_req && !busy;

  // A request arriving in the same cycle as the prefetch ack is folded in as if it had been
  // latched earlier, so the ack handling below only needs one view of the pending request.
  assign eff_pend     = pend_valid_q || req_ok;
  assign eff_pend_adr = req_ok ? pc_word : pend_adr_q;
  assign eff_discard  = discard_q || i_flush || (req_ok && (pc_word != adr_q));

  serv_ifetch_buf u_buf (
    .clk        (clk),
    .i_rst      (i_rst),
    .i_load     (buf_load),
    .i_load_adr (adr_q),
    .i_load_data(i_ibus_rdt[31:2]),
    .i_inval    (buf_inval),
    .i_cmp_adr  (pc_word),
    .o_hit      (buf_hit),
    .o_data     (buf_data)
  );

  always_comb begin
    state_d      = state_q;
    adr_d        = adr_q;
    pend_adr_d   = pend_adr_q;
    pend_valid_d = pend_valid_q;
    discard_d    = discard_q;
    wb_en_d      = 1'b0;
    wb_rdt_d     = wb_rdt_q;
    buf_load     = 1'b0;
    buf_inval    = i_flush;

    case (state_q)
      StIdle: begin
        if (i_fetch_req) begin
          if (buf_hit && !i_flush) begin
            wb_en_d   = 1'b1;
            wb_rdt_d  = buf_data;
            buf_inval = 1'b1;
            if (PREFETCH) begin
              state_d = StPref;
              adr_d   = next_word(pc_word);
            end
          end else begin
            state_d = StDemand;
            adr_d   = pc_word;
          end
        end
      end

      StDemand: begin
        if (i_ibus_ack) begin
          wb_en_d  = 1'b1;
          wb_rdt_d = i_ibus_rdt[31:2];
          if (PREFETCH) begin
            state_d = StPref;
            adr_d   = next_word(adr_q);
          end else begin
            state_d = StIdle;
          end
        end
      end

      StPref: begin
        pend_valid_d = eff_pend;
        pend_adr_d   = eff_pend_adr;
        discard_d    = eff_discard;
        if (i_ibus_ack) begin
          pend_valid_d = 1'b0;
          discard_d    = 1'b0;
          if (eff_pend && !eff_discard) begin
            // Core asked for exactly the word in flight: hand it over and keep streaming.
            wb_en_d  = 1'b1;
            wb_rdt_d = i_ibus_rdt[31:2];
            adr_d    = next_word(adr_q);
          end else if (eff_pend) begin
            state_d = StDemand;
            adr_d   = eff_pend_adr;
          end else begin
            buf_load = !eff_discard;
            state_d  = StIdle;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q      <= StIdle;
      adr_q        <= RESET_PC[31:2];
      pend_adr_q   <= '0;
      pend_valid_q <= 1'b0;
      discard_q    <= 1'b0;
      wb_en_q      <= 1'b0;
      wb_rdt_q     <= '0;
    end else begin
      state_q      <= state_d;
      adr_q        <= adr_d;
      pend_adr_q   <= pend_adr_d;
      pend_valid_q <= pend_valid_d;
      discard_q    <= discard_d;
      wb_en_q      <= wb_en_d;
      wb_rdt_q     <= wb_rdt_d;
    end
  end

  assign o_busy     = busy;
  assign o_ibus_cyc = (state_q != StIdle);
  assign o_ibus_adr = {adr_q, WB_ADR_ALIGN};
  assign o_wb_en    = wb_en_q;
  assign o_wb_rdt   = wb_rdt_q;

endmodule

// File: tb/tb_serv_ifetch.sv
// Directed bench: prefetching instance (RESET_PC=0x80) and a demand-only instance.
module tb_serv_ifetch;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;

  logic        req = 1'b0, flush = 1'b0, ack = 1'b0;
  logic [31:0] pc = '0, rdt = '0;
  logic        busy, cyc, wb_en;
  logic [31:0] adr;
  logic [29:0] wb_rdt;

  logic        req0 = 1'b0, ack0 = 1'b0;
  logic [31:0] pc0 = '0, rdt0 = '0;
  logic        busy0, cyc0, wb_en0;
  logic [31:0] adr0;
  logic [29:0] wb_rdt0;

  int total = 0;
  int bad = 0;
  logic wb_en_prev = 1'b0, wb_en0_prev = 1'b0;

  logic [31:0] seq_pc  [3] = '{32'h0000_0000, 32'h0000_0004, 32'h0000_0008};
  logic [31:0] seq_rdt [3] = '{32'h0000_0013, 32'h0010_0093, 32'h0020_0113};
  logic [31:0] seq_exp [3] = '{32'h0000_0004, 32'h0004_0024, 32'h0008_0044};

  always #5 clk = ~clk;

  serv_ifetch #(.RESET_PC(32'h0000_0080), .PREFETCH(1'b1)) dut (
    .clk(clk), .i_rst(i_rst), .i_fetch_req(req), .i_pc(pc), .i_flush(flush),
    .o_busy(busy), .o_ibus_adr(adr), .o_ibus_cyc(cyc), .i_ibus_rdt(rdt),
    .i_ibus_ack(ack), .o_wb_rdt(wb_rdt), .o_wb_en(wb_en)
  );

  serv_ifetch #(.RESET_PC(32'h0000_0000), .PREFETCH(1'b0)) dut0 (
    .clk(clk), .i_rst(i_rst), .i_fetch_req(req0), .i_pc(pc0), .i_flush(1'b0),
    .o_busy(busy0), .o_ibus_adr(adr0), .o_ibus_cyc(cyc0), .i_ibus_rdt(rdt0),
    .i_ibus_ack(ack0), .o_wb_rdt(wb_rdt0), .o_wb_en(wb_en0)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Protocol monitors: no request while busy, no back-to-back strobes, demand-only never idles on bus.
  always @(posedge clk) begin
    if (!i_rst && ((req && busy) || (req0 && busy0))) begin
      bad++;
      $error("FAIL req_while_busy: got 1 want 0");
    end
  end

  always @(negedge clk) begin
    if (!i_rst && ((wb_en && wb_en_prev) || (wb_en0 && wb_en0_prev))) begin
      bad++;
      $error("FAIL wb_en_back_to_back: got 1 want 0");
    end
    if (!i_rst && cyc0 && !busy0) begin
      bad++;
      $error("FAIL nopref_cyc_not_busy: got 1 want 0");
    end
    wb_en_prev  = wb_en;
    wb_en0_prev = wb_en0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(); tick();
    chk("rst_cyc", {31'd0, cyc}, 32'd0);
    chk("rst_wb_en", {31'd0, wb_en}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_wb_rdt", {2'd0, wb_rdt}, 32'd0);
    chk("rst_adr", adr, 32'h0000_0080);
    chk("rst_adr0", adr0, 32'h0000_0000);
    i_rst = 1'b0;
    tick();

    // Demand miss at 0x100, ack on the second bus cycle.
    pc = 32'h0000_0100; req = 1'b1; tick(); req = 1'b0;
    chk("miss_cyc", {31'd0, cyc}, 32'd1);
    chk("miss_adr", adr, 32'h0000_0100);
    chk("miss_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("miss_wait_en", {31'd0, wb_en}, 32'd0);
    rdt = 32'h0050_0093; ack = 1'b1; tick(); ack = 1'b0;
    chk("miss_en", {31'd0, wb_en}, 32'd1);
    chk("miss_rdt", {2'd0, wb_rdt}, 32'h0014_0024);
    chk("pref_cyc", {31'd0, cyc}, 32'd1);
    chk("pref_adr", adr, 32'h0000_0104);
    chk("pref_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("miss_en_once", {31'd0, wb_en}, 32'd0);

    // Prefetch of 0x104 lands in the buffer, then a hit.
    rdt = 32'h00A0_0113; ack = 1'b1; tick(); ack = 1'b0;
    chk("buf_fill_cyc", {31'd0, cyc}, 32'd0);
    chk("buf_fill_en", {31'd0, wb_en}, 32'd0);
    pc = 32'h0000_0104; req = 1'b1; tick(); req = 1'b0;
    chk("hit_en", {31'd0, wb_en}, 32'd1);
    chk("hit_rdt", {2'd0, wb_rdt}, 32'h0028_0044);
    chk("hit_pref_adr", adr, 32'h0000_0108);

    // Different-address request while prefetch 0x108 is in flight.
    pc = 32'h0000_0200; req = 1'b1; tick(); req = 1'b0;
    chk("redir_busy", {31'd0, busy}, 32'd1);
    chk("redir_keep_adr", adr, 32'h0000_0108);
    tick();
    rdt = 32'hDEAD_BEEF; ack = 1'b1; tick(); ack = 1'b0;
    chk("redir_drop_en", {31'd0, wb_en}, 32'd0);
    chk("redir_dem_adr", adr, 32'h0000_0200);
    chk("redir_dem_cyc", {31'd0, cyc}, 32'd1);
    rdt = 32'h1234_5678; ack = 1'b1; tick(); ack = 1'b0;
    chk("redir_en", {31'd0, wb_en}, 32'd1);
    chk("redir_rdt", {2'd0, wb_rdt}, 32'h048D_159E);
    chk("redir_pref_adr", adr, 32'h0000_0204);

    // Fill buffer at 0x204, miss 0x108, buffer refills at 0x10C; flush then req 0x10C misses.
    rdt = 32'h0000_0013; ack = 1'b1; tick(); ack = 1'b0;
    pc = 32'h0000_0108; req = 1'b1; tick(); req = 1'b0;
    chk("miss108_adr", adr, 32'h0000_0108);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("pref10c_adr", adr, 32'h0000_010C);
    ack = 1'b1; tick(); ack = 1'b0;
    flush = 1'b1; tick(); flush = 1'b0;
    chk("flush_cyc", {31'd0, cyc}, 32'd0);
    pc = 32'h0000_010C; req = 1'b1; tick(); req = 1'b0;
    chk("flush_miss_en", {31'd0, wb_en}, 32'd0);
    chk("flush_miss_cyc", {31'd0, cyc}, 32'd1);
    chk("flush_miss_adr", adr, 32'h0000_010C);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("flush_miss_rdt", {2'd0, wb_rdt}, 32'h0000_0004);

    // Buffer valid at 0x110; flush and hit-req in the same cycle becomes a miss.
    ack = 1'b1; tick(); ack = 1'b0;
    pc = 32'h0000_0110; req = 1'b1; flush = 1'b1; tick(); req = 1'b0; flush = 1'b0;
    chk("flushreq_en", {31'd0, wb_en}, 32'd0);
    chk("flushreq_busy", {31'd0, busy}, 32'd1);
    chk("flushreq_adr", adr, 32'h0000_0110);
    rdt = 32'hAAAA_AAA8; ack = 1'b1; tick(); ack = 1'b0;
    chk("flushreq_rdt", {2'd0, wb_rdt}, 32'h2AAA_AAAA);

    // Address wrap on the top word, then same-address request during that prefetch.
    ack = 1'b1; tick(); ack = 1'b0;
    pc = 32'hFFFF_FFFC; req = 1'b1; tick(); req = 1'b0;
    chk("wrap_dem_adr", adr, 32'hFFFF_FFFC);
    rdt = 32'h0000_0073; ack = 1'b1; tick(); ack = 1'b0;
    chk("wrap_rdt", {2'd0, wb_rdt}, 32'h0000_001C);
    chk("wrap_pref_adr", adr, 32'h0000_0000);
    pc = 32'h0000_0000; req = 1'b1; tick(); req = 1'b0;
    chk("same_busy", {31'd0, busy}, 32'd1);
    chk("same_wait_en", {31'd0, wb_en}, 32'd0);
    rdt = 32'h0010_0073; ack = 1'b1; tick(); ack = 1'b0;
    chk("same_en", {31'd0, wb_en}, 32'd1);
    chk("same_rdt", {2'd0, wb_rdt}, 32'h0004_001C);
    chk("same_chain_adr", adr, 32'h0000_0004);
    chk("same_busy_done", {31'd0, busy}, 32'd0);

    // Buffer at 0x4, demand 0x300, reset mid-cycle.
    ack = 1'b1; tick(); ack = 1'b0;
    pc = 32'h0000_0300; req = 1'b1; tick(); req = 1'b0;
    chk("pre_rst_cyc", {31'd0, cyc}, 32'd1);
    i_rst = 1'b1; tick();
    chk("midrst_cyc", {31'd0, cyc}, 32'd0);
    chk("midrst_en", {31'd0, wb_en}, 32'd0);
    chk("midrst_adr", adr, 32'h0000_0080);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    i_rst = 1'b0; tick();
    pc = 32'h0000_0004; req = 1'b1; tick(); req = 1'b0;
    chk("postrst_miss_en", {31'd0, wb_en}, 32'd0);
    chk("postrst_miss_cyc", {31'd0, cyc}, 32'd1);

    // Demand-only instance: every request is its own bus cycle.
    for (int i = 0; i < 3; i++) begin
      chk("nopref_idle_cyc", {31'd0, cyc0}, 32'd0);
      pc0 = seq_pc[i]; req0 = 1'b1; tick(); req0 = 1'b0;
      chk("nopref_cyc", {31'd0, cyc0}, 32'd1);
      chk("nopref_adr", adr0, seq_pc[i]);
      rdt0 = seq_rdt[i]; ack0 = 1'b1; tick(); ack0 = 1'b0;
      chk("nopref_en", {31'd0, wb_en0}, 32'd1);
      chk("nopref_rdt", {2'd0, wb_rdt0}, seq_exp[i]);
      chk("nopref_cyc_drop", {31'd0, cyc0}, 32'd0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
